// File: rtl/fifo_rd_stream.sv
// Read-side adapter for the dual-clock FIFO: turns the registered-latency read port into a
// valid/ready stream with packet framing, using a 3-entry prefetch buffer.
module fifo_rd_stream #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned PKT_LEN    = 4,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  rd_clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic [CNT_WIDTH-1:0]  word_cnt
);

  localparam int unsigned BeatW = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
  localparam logic [BeatW-1:0] BeatMax = BeatW'(PKT_LEN - 1);

  logic [DATA_WIDTH-1:0] mem_q [3];
  logic [1:0]            occ_q, occ_d;
  logic [1:0]            head_q, head_d;
  logic [1:0]            tail_q, tail_d;
  logic                  inflight_q;
  logic [BeatW-1:0]      beat_q, beat_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  pop;
  logic [2:0]            committed;

  function automatic logic [1:0] inc3(input logic [1:0] idx);
    return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
  endfunction

  // Read issue depends only on registered occupancy, never on m_ready.
  always_comb begin
    committed  = {1'b0, occ_q} + {2'b00, inflight_q};
    fifo_rd_en = en & ~fifo_empty & ~rst & (committed < 3'd3);
    m_valid    = (occ_q != 2'd0);
    m_data     = mem_q[head_q];
    m_last     = m_valid & (beat_q == BeatMax);
    pop        = m_valid & m_ready;
    word_cnt   = cnt_q;
  end

  always_comb begin
    head_d = pop ? inc3(head_q) : head_q;
    tail_d = inflight_q ? inc3(tail_q) : tail_q;
    occ_d  = occ_q + {1'b0, inflight_q} - {1'b0, pop};
    beat_d = beat_q;
    cnt_d  = cnt_q;
    if (pop) begin
      beat_d = (beat_q == BeatMax) ? '0 : beat_q + BeatW'(1);
      cnt_d  = cnt_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge rd_clk) begin
    if (rst) begin
      occ_q      <= 2'd0;
      head_q     <= 2'd0;
      tail_q     <= 2'd0;
      inflight_q <= 1'b0;
      beat_q     <= '0;
      cnt_q      <= '0;
    end else begin
      occ_q      <= occ_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      inflight_q <= fifo_rd_en;
      beat_q     <= beat_d;
      cnt_q      <= cnt_d;
    end
  end

  // Data storage needs no reset; an in-flight word is dropped by gating the write.
  always_ff @(posedge rd_clk) begin
    if (!rst && inflight_q) begin
      mem_q[tail_q] <= fifo_data;
    end
  end

  a_no_overflow: assert property (@(posedge rd_clk) disable iff (rst) committed <= 3'd3);

endmodule

// File: doc/fifo_rd_stream.md
# fifo_rd_stream

Read-side adapter for the dual-clock FIFO, living entirely in the read clock domain. It pulls words from the FIFO read port (rd_en/data_out/empty, one-cycle registered read latency) and presents them as a valid/ready stream with packet framing. A 3-entry prefetch buffer sustains one word per cycle. There is no combinational path from m_ready to the FIFO read enable.

## Interface
Parameters:
- DATA_WIDTH, 8, word width; must match the FIFO.
- PKT_LEN, 4, beats per packet; m_last marks every PKT_LEN-th accepted beat; must be ≥1.
- CNT_WIDTH, 16, width of the delivered-word statistics counter.

Ports:
- rd_clk  in  1  single clock (FIFO read clock).
- rst  in  1  reset, synchronous to rd_clk, active-high.
- en  in  1  when low, no new FIFO reads are issued; buffered and in-flight words still drain.
- fifo_empty  in  1  FIFO empty flag.
- fifo_rd_en  out  1  FIFO read request.
- fifo_data  in  DATA_WIDTH  FIFO data_out, valid the cycle after a granted read.
- m_valid  out  1  stream word available.
- m_ready  in  1  downstream accepts.
- m_data  out  DATA_WIDTH  stream word (buffer head).
- m_last  out  1  final beat of the current packet.
- word_cnt  out  CNT_WIDTH  total words accepted downstream; wraps modulo 2^CNT_WIDTH.

## Operation
- State:
  - occ (0..3): buffer occupancy, circular 3-entry buffer with head and tail indices.
  - inflight (1 bit): a read was granted last cycle.
  - beat (0..PKT_LEN-1): position within the current packet.
  - word_cnt.
- Read issue (registered terms only):
  - fifo_rd_en = en & ~fifo_empty & ~rst & (occ + inflight < 3).
  - inflight <= fifo_rd_en.
- Capture: when inflight=1, fifo_data is written at tail, then tail advances mod 3.
- Pop: on m_valid & m_ready, head advances mod 3.
- occ next = occ + inflight − pop; push and pop may occur in the same cycle.
- Invariant: occ + inflight ≤ 3. Overflow is impossible by construction; checker asserts it.
- Outputs:
  - m_valid = (occ ≠ 0).
  - m_data = buf[head].
  - m_last = m_valid & (beat == PKT_LEN−1).
  - m_data and m_last stay stable while m_valid & ~m_ready.
- Accepted beat:
  - beat returns to 0 if beat == PKT_LEN−1, else increments.
  - word_cnt increments by 1, wrapping.
- PKT_LEN=1: m_last = m_valid on every beat.
- en deassert mid-stream: a grant already issued still captures its word; the packet beat count is preserved across pauses.
- Reset (rst=1 at a rd_clk edge):
  - occ, head, tail, inflight, beat and word_cnt all go to 0.
  - Outputs: m_valid=0, m_last=0, fifo_rd_en=0 (combinationally forced during rst), m_data is don't-care.
  - An in-flight word is discarded. The system resets the FIFO together with this block.

## Timing
- Read latency: fifo_rd_en high in cycle T, fifo_data valid in T+1, captured at the end of T+1, m_valid high in T+2.
- Empty-to-first-beat: 2 cycles after fifo_empty falls (with en=1, occ=0).
- Throughput: 1 word per cycle sustained when the FIFO is non-empty and m_ready=1 (steady state occ=1, inflight=1).
- Backpressure:
  - After m_ready falls, at most the in-flight word is still captured.
  - Reads stop once occ + inflight = 3.
  - Reads resume the cycle after a pop frees space, giving a 1-cycle bubble on the FIFO side only.
- First cycle after rst falls: fifo_rd_en may assert if the FIFO is non-empty.

## Test plan
- Basic: FIFO holds 0x11,0x22,0x33,0x44, m_ready=1, PKT_LEN=4 → first m_valid 2 cycles after the first fifo_rd_en; beats on consecutive cycles; m_last only with 0x44; word_cnt=4.
- Backpressure: 8 words, m_ready low for 5 cycles → fifo_rd_en stops after 3 grants, occ=3, no word lost or duplicated; order 1..8 preserved when m_ready returns.
- Empty/refill: FIFO goes empty mid-packet (2 of 4 beats), refilled 10 cycles later → m_valid low in the gap; m_last on the 4th overall beat.
- en pause: en=0 for 6 cycles while streaming → at most one extra word captured after en falls; buffer drains; beat count continues correctly after en=1.
- Reset mid-operation: rst for 1 cycle with occ=2 and inflight=1 → next cycle m_valid=0, word_cnt=0, beat=0; subsequent packet's m_last on its 4th beat.
- Wrap: CNT_WIDTH=4, 17 accepted words → word_cnt=1; head/tail wrap mod 3 with data order intact.
